// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - two-requester round-robin arbiter sharing one add/sub unit
// Registered result slot with one-cycle latency and back-to-back replace on drain.
module addsub_arbiter #(
    parameter int WIDTH = 36,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic             r0_sub,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic             r1_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_id,
    output logic [CNT_W-1:0] grant_cnt
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_carry_q, out_carry_d;
    logic             out_id_q, out_id_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;

    logic             slot_free;
    logic             gnt0, gnt1, gnt_any;
    logic [WIDTH-1:0] op_a, op_b, op_b_eff;
    logic             op_sub;
    logic [WIDTH:0]   sum;

    assign slot_free = !out_valid_q || out_ready;

    // Pointer side wins only on contention; a lone requester always wins.
    assign gnt0    = !reset && slot_free && r0_valid && (!r1_valid || !ptr_q);
    assign gnt1    = !reset && slot_free && r1_valid && (!r0_valid ||  ptr_q);
    assign gnt_any = gnt0 || gnt1;

    assign r0_ready = gnt0;
    assign r1_ready = gnt1;

    // Single shared adder; subtract is a + ~b + 1 so carry=1 means no borrow.
    assign op_a     = gnt1 ? r1_a   : r0_a;
    assign op_b     = gnt1 ? r1_b   : r0_b;
    assign op_sub   = gnt1 ? r1_sub : r0_sub;
    assign op_b_eff = op_sub ? ~op_b : op_b;
    assign sum      = {1'b0, op_a} + {1'b0, op_b_eff} + {{WIDTH{1'b0}}, op_sub};

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_carry_d = out_carry_q;
        out_id_d    = out_id_q;
        ptr_d       = ptr_q;
        grant_cnt_d = grant_cnt_q;
        if (gnt_any) begin
            out_valid_d = 1'b1;
            out_data_d  = sum[WIDTH-1:0];
            out_carry_d = sum[WIDTH];
            out_id_d    = gnt1;
            ptr_d       = !gnt1;
            grant_cnt_d = grant_cnt_q + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_carry_q <= 1'b0;
            out_id_q    <= 1'b0;
            ptr_q       <= 1'b0;
            grant_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_carry_q <= out_carry_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_carry = out_carry_q;
    assign out_id    = out_id_q;
    assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - directed self-checking bench for addsub_arbiter
module tb_addsub_arbiter;

    localparam int WIDTH = 36;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             r0_valid, r1_valid;
    logic             r0_ready, r1_ready;
    logic [WIDTH-1:0] r0_a, r0_b, r1_a, r1_b;
    logic             r0_sub, r1_sub;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry, out_id;
    logic [CNT_W-1:0] grant_cnt;

    int checks = 0;
    int failures = 0;

    addsub_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_sub(r0_sub),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_sub(r1_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_carry(out_carry), .out_id(out_id), .grant_cnt(grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [WIDTH-1:0] d,
                           input logic c, input logic id, input logic [CNT_W-1:0] cnt);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".data"},  64'(out_data),  64'(d));
        chk({tag, ".carry"}, 64'(out_carry), 64'(c));
        chk({tag, ".id"},    64'(out_id),    64'(id));
        chk({tag, ".cnt"},   64'(grant_cnt), 64'(cnt));
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b0;
        r0_valid = 1'b1; r0_a = '0; r0_b = '0; r0_sub = 1'b0;
        r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_sub = 1'b0;
        step(); step();
        chk_out("reset", 1'b0, '0, 1'b0, 1'b0, '0);
        chk("reset.r0_ready", 64'(r0_ready), 64'd0);

        // r0 add 5+3
        reset = 1'b0; out_ready = 1'b1;
        r0_a = 36'd5; r0_b = 36'd3; r0_sub = 1'b0;
        #1;
        chk("add.r0_ready", 64'(r0_ready), 64'd1);
        chk("add.r1_ready", 64'(r1_ready), 64'd0);
        step();
        chk_out("add", 1'b1, 36'd8, 1'b0, 1'b0, 16'd1);

        // r1 sub 5-3, then 3-5
        r0_valid = 1'b0; r1_valid = 1'b1;
        r1_a = 36'd5; r1_b = 36'd3; r1_sub = 1'b1;
        #1;
        chk("sub.r1_ready", 64'(r1_ready), 64'd1);
        step();
        chk_out("sub1", 1'b1, 36'd2, 1'b1, 1'b1, 16'd2);
        r1_a = 36'd3; r1_b = 36'd5;
        step();
        chk_out("sub2", 1'b1, 36'hFFFFFFFFE, 1'b0, 1'b1, 16'd3);

        // r0 add overflow
        r1_valid = 1'b0; r0_valid = 1'b1;
        r0_a = 36'hFFFFFFFFF; r0_b = 36'd1; r0_sub = 1'b0;
        step();
        chk_out("ovf", 1'b1, 36'd0, 1'b1, 1'b0, 16'd4);

        // stall with both valid; pointer now on r1
        out_ready = 1'b0; r1_valid = 1'b1;
        r0_a = 36'd10; r0_b = 36'd1; r0_sub = 1'b0;
        r1_a = 36'd20; r1_b = 36'd2; r1_sub = 1'b1;
        #1;
        chk("stall.r0_ready", 64'(r0_ready), 64'd0);
        chk("stall.r1_ready", 64'(r1_ready), 64'd0);
        step(); r0_a = 36'd99;
        step(); r1_b = 36'd7;
        step(); r1_b = 36'd2;
        #1;
        chk("stall.r0_ready3", 64'(r0_ready), 64'd0);
        chk("stall.r1_ready3", 64'(r1_ready), 64'd0);
        chk_out("stall", 1'b1, 36'd0, 1'b1, 1'b0, 16'd4);

        // drain plus new grant, pointer-side winner r1: 20-2
        out_ready = 1'b1;
        #1;
        chk("drain.r1_ready", 64'(r1_ready), 64'd1);
        chk("drain.r0_ready", 64'(r0_ready), 64'd0);
        step();
        chk_out("drain", 1'b1, 36'h12, 1'b1, 1'b1, 16'd5);
        #1;
        chk("next.r0_ready", 64'(r0_ready), 64'd1);

        // reset while a result is pending and r0 requests
        reset = 1'b1; r1_valid = 1'b0;
        #1;
        chk("rst.r0_ready", 64'(r0_ready), 64'd0);
        step();
        chk_out("rst", 1'b0, '0, 1'b0, 1'b0, '0);

        // both valid continuously: 0,1,0,1
        reset = 1'b0; r1_valid = 1'b1;
        r0_a = 36'd1; r0_b = 36'd1; r0_sub = 1'b0;
        r1_a = 36'd7; r1_b = 36'd3; r1_sub = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr.r0_ready", 64'(r0_ready), 64'((i % 2) == 0));
            chk("rr.r1_ready", 64'(r1_ready), 64'((i % 2) == 1));
            step();
            chk_out("rr", 1'b1, ((i % 2) == 1) ? 36'd4 : 36'd2, (i % 2) == 1,
                    (i % 2) == 1, CNT_W'(i + 1));
        end

        // no requests: drain, outputs hold
        r0_valid = 1'b0; r1_valid = 1'b0;
        step();
        chk_out("idle", 1'b0, 36'd4, 1'b1, 1'b1, 16'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter: WIDTH, 36, operand and result width in bits.
REQ-002 Parameter: CNT_W, 16, width of the grant counter.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: r0_valid / r1_valid  input  1  requester 0/1 has an operation pending.
REQ-006 Port: r0_ready / r1_ready  output  1  requester 0/1 operation accepted this cycle.
REQ-007 Port: r0_a, r0_b / r1_a, r1_b  input  WIDTH  operands of requester 0/1.
REQ-008 Port: r0_sub / r1_sub  input  1  1 = a - b, 0 = a + b.
REQ-009 Port: out_valid  output  1  result register holds an undelivered result.
REQ-010 Port: out_ready  input  1  consumer accepts the result this cycle.
REQ-011 Port: out_data  output  WIDTH  registered result.
REQ-012 Port: out_carry  output  1  carry out of bit WIDTH-1 of the addition.
REQ-013 Port: out_id  output  1  index of the requester that produced out_data.
REQ-014 Port: grant_cnt  output  CNT_W  number of accepted operations since reset, wrapping.

Function
REQ-015 The block SHALL own exactly one WIDTH-bit add/sub unit shared by both requesters; at most one operation is accepted per cycle.
REQ-016 Add SHALL compute {carry,data} = a + b; subtract SHALL compute {carry,data} = a + ~b + 1 (carry=1 means no borrow); results are modulo 2^WIDTH.
REQ-017 slot_free SHALL be (!out_valid || out_ready), computed combinationally in the current cycle.
REQ-018 rN_ready SHALL be combinational: asserted only when slot_free, rN_valid, and N wins arbitration; never asserted while reset is high.
REQ-019 Arbitration SHALL be round-robin with a 1-bit priority pointer: if only one requester is valid it wins; if both are valid the pointer side wins.
REQ-020 After any grant to requester N the pointer SHALL become 1-N; with no grant the pointer SHALL hold.
REQ-021 On a grant, the next edge SHALL load out_data, out_carry and out_id from the winner and set out_valid=1 (latency: one cycle from acceptance to out_valid).
REQ-022 With out_valid=1 and out_ready=0, out_data, out_carry and out_id SHALL hold stable and both rN_ready SHALL be 0.
REQ-023 With out_valid=1 and out_ready=1 and a grant in the same cycle, the new result SHALL replace the old one with no bubble (one result per cycle sustained).
REQ-024 With out_ready=1 and no grant, out_valid SHALL clear on the next edge; out_data, out_carry and out_id hold their last values.
REQ-025 grant_cnt SHALL increment by 1 on each grant and wrap from 2^CNT_W-1 to 0.
REQ-026 Requester inputs SHALL be sampled only in a granted cycle; changes to a non-granted requester's operands SHALL not affect outputs.
REQ-027 The block SHALL hold no state other than out_valid, out_data, out_carry, out_id, the pointer and grant_cnt.

Reset
REQ-028 While reset is high at an edge: out_valid=0, out_data=0, out_carry=0, out_id=0, pointer=0 (requester 0 first), grant_cnt=0.
REQ-029 Reset SHALL take priority over any simultaneous grant or drain; a result pending at reset is discarded, and no grant is counted in that cycle.

Verification
REQ-030 r0 add a=5 b=3, out_ready=1 -> r0_ready=1 same cycle; next cycle out_valid=1, out_data=8, out_carry=0, out_id=0, grant_cnt=1.
REQ-031 r1 sub a=5 b=3 -> out_data=2, carry=1; r1 sub a=3 b=5 -> out_data=36'hFFFFFFFFE, carry=0, out_id=1.
REQ-032 r0 add a=36'hFFFFFFFFF b=1 -> out_data=0, out_carry=1.
REQ-033 Both valid continuously, out_ready=1 -> grants 0,1,0,1,... one per cycle; out_id alternates starting at 0; grant_cnt increments every cycle.
REQ-034 Result pending, out_ready=0 for 3 cycles with both valid -> both ready=0, outputs stable; raise out_ready -> drain and new grant in the same cycle, pointer-side winner.
REQ-035 Assert reset one cycle while out_valid=1 and r0_valid=1 -> next cycle out_valid=0, grant_cnt=0, r0 wins the first grant after reset deasserts.
